// File: rtl/pool_buf_arbiter.sv
// Shares the pooled-feature-map RAM port between the pool engine and the next-layer conv reader,
// and hands buffer ownership back and forth between FILL and DRAIN.
module pool_buf_arbiter #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned POOL_ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY      = 2,
  parameter int unsigned EXPECTED_WRITES = 144,
  parameter int unsigned WCNT_WIDTH      = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       conv_done,
  input  logic                       pool_rden,
  input  logic                       pool_wren,
  input  logic [POOL_ADDR_WIDTH-1:0] pool_addr,
  input  logic [DATA_WIDTH-1:0]      pool_data,
  output logic [DATA_WIDTH-1:0]      pool_q,
  input  logic                       rd_req,
  input  logic [POOL_ADDR_WIDTH-1:0] rd_addr,
  output logic                       rd_gnt,
  output logic                       rd_valid,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       buf_ready,
  input  logic                       buf_release,
  output logic                       err_overrun,
  output logic                       err_short,
  output logic                       ram_rden,
  output logic                       ram_wren,
  output logic [POOL_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]      ram_data,
  input  logic [DATA_WIDTH-1:0]      ram_q
);

  localparam logic [WCNT_WIDTH-1:0] ExpWrites = WCNT_WIDTH'(EXPECTED_WRITES);

  typedef enum logic [0:0] {StFill, StDrain} state_e;

  state_e                  state_q, state_d;
  logic                    conv_done_dl_q;
  logic                    fend;
  logic [WCNT_WIDTH-1:0]   wcnt_q, wcnt_d;
  logic                    err_overrun_q, err_overrun_d;
  logic                    err_short_q, err_short_d;
  logic                    pool_act;
  logic [RD_LATENCY-1:0]   cons_pipe_q, pool_pipe_q;
  logic [RD_LATENCY:0]     cons_tag, pool_tag;
  logic [DATA_WIDTH-1:0]   rd_data_q;

  assign fend     = ~conv_done & conv_done_dl_q;
  assign pool_act = pool_rden | pool_wren;

  assign buf_ready   = (state_q == StDrain);
  assign rd_gnt      = buf_ready & rd_req & ~pool_act;
  assign err_overrun = err_overrun_q;
  assign err_short   = err_short_q;
  assign pool_q      = ram_q;

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    err_overrun_d = err_overrun_q;
    err_short_d   = err_short_q;
    unique case (state_q)
      StFill: begin
        if (fend) begin
          state_d = StDrain;
          wcnt_d  = '0;
          if (wcnt_q != ExpWrites) err_short_d = 1'b1;
        end else if (pool_wren && (wcnt_q != '1)) begin
          wcnt_d = wcnt_q + WCNT_WIDTH'(1);
        end
      end
      StDrain: begin
        if (pool_act || fend) err_overrun_d = 1'b1;
        if (buf_release) state_d = StFill;
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StFill;
      wcnt_q         <= '0;
      conv_done_dl_q <= 1'b0;
      err_overrun_q  <= 1'b0;
      err_short_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      conv_done_dl_q <= conv_done;
      err_overrun_q  <= err_overrun_d;
      err_short_q    <= err_short_d;
    end
  end

  // Pool traffic always takes the port; the consumer only gets it on an idle pool cycle.
  always_comb begin
    ram_rden = 1'b0;
    ram_wren = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (pool_act) begin
      ram_rden = pool_rden;
      ram_wren = pool_wren;
      ram_addr = pool_addr;
      ram_data = pool_data;
    end else if (rd_gnt) begin
      ram_rden = 1'b1;
      ram_addr = rd_addr;
    end
  end

  // Tag index k is the read issued k cycles ago; the RAM word for it is captured one
  // stage before the top so rd_valid and rd_data leave registered together.
  assign cons_tag = {cons_pipe_q, rd_gnt};
  assign pool_tag = {pool_pipe_q, pool_rden};
  assign rd_valid = cons_tag[RD_LATENCY] & ~pool_tag[RD_LATENCY];
  assign rd_data  = rd_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cons_pipe_q <= '0;
      pool_pipe_q <= '0;
      rd_data_q   <= '0;
    end else begin
      cons_pipe_q <= cons_tag[RD_LATENCY-1:0];
      pool_pipe_q <= pool_tag[RD_LATENCY-1:0];
      if (cons_tag[RD_LATENCY-1] && !pool_tag[RD_LATENCY-1]) rd_data_q <= ram_q;
    end
  end

endmodule

// File: tb/tb_pool_buf_arbiter.sv
// Directed bench for pool_buf_arbiter: a RAM model with one registered read stage, a scoreboard
// queue of expected consumer reads, and a monitor that pops on every rd_valid.
module tb_pool_buf_arbiter;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 2;

  logic          clk, reset, conv_done;
  logic          pool_rden, pool_wren;
  logic [AW-1:0] pool_addr, rd_addr, ram_addr;
  logic [DW-1:0] pool_data, pool_q, rd_data, ram_data, ram_q;
  logic          rd_req, rd_gnt, rd_valid, buf_ready, buf_release;
  logic          err_overrun, err_short, ram_rden, ram_wren;

  pool_buf_arbiter #(
    .DATA_WIDTH     (DW),
    .POOL_ADDR_WIDTH(AW),
    .RD_LATENCY     (LAT),
    .EXPECTED_WRITES(144),
    .WCNT_WIDTH     (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .conv_done  (conv_done),
    .pool_rden  (pool_rden),
    .pool_wren  (pool_wren),
    .pool_addr  (pool_addr),
    .pool_data  (pool_data),
    .pool_q     (pool_q),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .buf_ready  (buf_ready),
    .buf_release(buf_release),
    .err_overrun(err_overrun),
    .err_short  (err_short),
    .ram_rden   (ram_rden),
    .ram_wren   (ram_wren),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_q      (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: the word appears on ram_q one cycle after the read address.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (ram_wren) mem[ram_addr] <= ram_data;
  always @(posedge clk or posedge reset) begin
    if (reset) ram_q <= '0;
    else if (ram_rden) ram_q <= mem[ram_addr];
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests;
  int n_fail;
  logic [31:0] exp_data_q [$];
  logic [31:0] exp_cyc_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [31:0] mon_d, mon_c;
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_data_q.size() == 0) begin
        check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        mon_d = exp_data_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("rd_data", 32'(rd_data), mon_d);
        check("rd_valid_cycle", 32'(cyc), mon_c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input int addr);
    exp_data_q.push_back(32'(addr * 3));
    exp_cyc_q.push_back(32'(cyc + LAT));
  endtask

  task automatic frame(input int n, input logic exp_short);
    conv_done = 1'b1;
    for (int i = 0; i < n; i++) begin
      pool_wren = 1'b1;
      pool_addr = AW'(i);
      pool_data = DW'(i * 3);
      if (i == 5) begin
        @(negedge clk);
        check("fill_ram_wren", 32'(ram_wren), 32'd1);
        check("fill_ram_addr", 32'(ram_addr), 32'd5);
        check("fill_ram_data", 32'(ram_data), 32'd15);
      end
      step();
    end
    pool_wren = 1'b0;
    step();
    conv_done = 1'b0;
    @(negedge clk);
    check("buf_ready_fend_cycle", 32'(buf_ready), 32'd0);
    step();
    @(negedge clk);
    check("buf_ready_after_fend", 32'(buf_ready), 32'd1);
    check("err_short", 32'(err_short), 32'(exp_short));
    step();
  endtask

  // Consumer streams n reads from base; a pool write is injected on iteration pool_k (-1: none).
  task automatic drain_reads(input int base, input int n, input int pool_k);
    int got;
    int k;
    logic eg;
    got = 0;
    k   = 0;
    rd_req = 1'b1;
    while (got < n && k < n + 4) begin
      rd_addr   = AW'(base + got);
      pool_wren = (k == pool_k);
      pool_addr = AW'(200);
      pool_data = 16'hBEEF;
      @(negedge clk);
      eg = (k != pool_k);
      check("drain_rd_gnt", 32'(rd_gnt), 32'(eg));
      if (k == pool_k) begin
        check("pool_win_ram_wren", 32'(ram_wren), 32'd1);
        check("pool_win_ram_addr", 32'(ram_addr), 32'd200);
        check("overrun_before", 32'(err_overrun), 32'd0);
      end
      if (pool_k >= 0 && k == pool_k + 1) check("overrun_after", 32'(err_overrun), 32'd1);
      if (eg) begin
        push_read(base + got);
        got++;
      end
      step();
      k++;
    end
    if (got != n) check("drain_budget", 32'(got), 32'(n));
    rd_req    = 1'b0;
    pool_wren = 1'b0;
    repeat (4) step();
    check("sb_empty", 32'(exp_data_q.size()), 32'd0);
    check("rd_data_hold", 32'(rd_data), 32'((base + n - 1) * 3));
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; conv_done = 1'b0; pool_rden = 1'b0; pool_wren = 1'b0;
    pool_addr = '0; pool_data = '0; rd_req = 1'b0; rd_addr = '0; buf_release = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_buf_ready", 32'(buf_ready), 32'd0);
    check("rst_rd_gnt", 32'(rd_gnt), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_errs", 32'({err_overrun, err_short}), 32'd0);
    step();
    reset = 1'b0;

    // FILL: consumer locked out, RAM reads follow the pool engine, release ignored.
    for (int i = 0; i < 20; i++) begin
      rd_req      = 1'b1;
      rd_addr     = AW'(i);
      pool_rden   = i[0];
      pool_addr   = AW'(i + 300);
      buf_release = (i == 10);
      @(negedge clk);
      check("fill_rd_gnt", 32'(rd_gnt), 32'd0);
      check("fill_ram_rden", 32'(ram_rden), 32'(i % 2));
      check("fill_buf_ready", 32'(buf_ready), 32'd0);
      if (i[0]) check("fill_ram_addr", 32'(ram_addr), 32'(i + 300));
      step();
    end
    rd_req = 1'b0; pool_rden = 1'b0; buf_release = 1'b0;

    frame(144, 1'b0);
    drain_reads(0, 8, -1);
    drain_reads(8, 8, 4);

    pool_rden = 1'b1;
    pool_addr = AW'(200);
    step();
    pool_rden = 1'b0;
    @(negedge clk);
    check("pool_q_passthru", 32'(pool_q), 32'h0000BEEF);
    step();

    // Release with a read granted the same cycle: its data lands in FILL.
    rd_req = 1'b1; rd_addr = AW'(5); buf_release = 1'b1;
    @(negedge clk);
    check("release_rd_gnt", 32'(rd_gnt), 32'd1);
    check("release_buf_ready", 32'(buf_ready), 32'd1);
    push_read(5);
    step();
    rd_req = 1'b0; buf_release = 1'b0;
    @(negedge clk);
    check("post_release_buf_ready", 32'(buf_ready), 32'd0);
    repeat (3) step();
    check("sb_empty_release", 32'(exp_data_q.size()), 32'd0);

    frame(144, 1'b0);
    buf_release = 1'b1;
    step();
    buf_release = 1'b0;
    frame(143, 1'b1);
    check("overrun_sticky", 32'(err_overrun), 32'd1);

    // Two consumer reads in flight, then reset: neither may produce rd_valid.
    rd_req = 1'b1; rd_addr = AW'(0);
    @(negedge clk);
    check("inflight_gnt0", 32'(rd_gnt), 32'd1);
    step();
    rd_addr = AW'(1);
    @(negedge clk);
    check("inflight_gnt1", 32'(rd_gnt), 32'd1);
    #1 reset = 1'b1;
    rd_req = 1'b0;
    #1;
    check("mid_rst_buf_ready", 32'(buf_ready), 32'd0);
    check("mid_rst_rd_gnt", 32'(rd_gnt), 32'd0);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    check("mid_rst_pool_q", 32'(pool_q), 32'd0);
    check("mid_rst_errs", 32'({err_overrun, err_short}), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    repeat (5) step();
    check("sb_empty_final", 32'(exp_data_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
